// File: rtl/signal_merge.sv
// signal_merge: pairs two signed AXI-Stream channels into one {ch2, ch1} word through 2-deep per-channel FIFOs.
// Define SIGNAL_MERGE_SAT_EN for saturating packing with sticky clip flags; otherwise halves wrap around.
`timescale 1ns/1ps
module signal_merge #(
    parameter int unsigned ADC_DATA_WIDTH   = 16,
    parameter int unsigned AXIS_TDATA_WIDTH = 32,
    parameter int unsigned SHIFT            = 0
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata_PORT1,
    input  logic                        S_AXIS_tvalid_PORT1,
    output logic                        S_AXIS_tready_PORT1,
    input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata_PORT2,
    input  logic                        S_AXIS_tvalid_PORT2,
    output logic                        S_AXIS_tready_PORT2,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
    output logic                        M_AXIS_tvalid,
    input  logic                        M_AXIS_tready,
    input  logic                        sat_clr,
    output logic [1:0]                  sat_flag
);
    localparam int unsigned DW = AXIS_TDATA_WIDTH;
    localparam int unsigned AW = ADC_DATA_WIDTH;

    logic [DW-1:0]        in_data [2];
    logic [1:0]           in_valid;
    logic [DW-1:0]        mem_q   [2][2];
    logic [1:0]           cnt_q   [2];
    logic [1:0]           cnt_d   [2];
    logic [1:0]           wr_q, wr_d;
    logic [1:0]           rd_q, rd_d;
    logic [1:0]           rdy_q, rdy_d;
    logic [1:0]           push;
    logic [1:0]           nonempty;
    logic                 load;
    logic signed [DW-1:0] s       [2];
    logic [AW-1:0]        half    [2];
    logic [1:0]           clip;
    logic                 mvalid_q, mvalid_d;
    logic [DW-1:0]        mdata_q, mdata_d;
    logic [1:0]           sat_q, sat_d;

    assign in_data[0] = S_AXIS_tdata_PORT1;
    assign in_data[1] = S_AXIS_tdata_PORT2;
    assign in_valid   = {S_AXIS_tvalid_PORT2, S_AXIS_tvalid_PORT1};

    // Both heads leave together, so pairing always follows arrival order.
    assign push     = in_valid & rdy_q;
    assign nonempty = {cnt_q[1] != 2'd0, cnt_q[0] != 2'd0};
    assign load     = (&nonempty) && (!mvalid_q || M_AXIS_tready);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        rdy_d = 2'b00;
        for (int c = 0; c < 2; c++) begin
            cnt_d[c] = cnt_q[c];
            if (push[c] && !load) begin
                cnt_d[c] = cnt_q[c] + 2'd1;
            end else if (!push[c] && load) begin
                cnt_d[c] = cnt_q[c] - 2'd1;
            end
            rdy_d[c] = (cnt_d[c] != 2'd2);
            if (push[c]) wr_d[c] = ~wr_q[c];
            if (load)    rd_d[c] = ~rd_q[c];
        end
    end

    // Per-channel shift and narrowing of the FIFO head.
    always_comb begin
        clip = 2'b00;
        for (int c = 0; c < 2; c++) begin
            s[c] = $signed(mem_q[c][rd_q[c]]) >>> SHIFT;
`ifdef SIGNAL_MERGE_SAT_EN
            clip[c] = !((&s[c][DW-1:AW-1]) || !(|s[c][DW-1:AW-1]));
            if (clip[c]) begin
                half[c] = s[c][DW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
            end else begin
                half[c] = AW'(s[c]);
            end
`else
            half[c] = AW'(s[c]);
`endif
        end
    end

    always_comb begin
        mvalid_d = mvalid_q;
        mdata_d  = mdata_q;
        if (load) begin
            mvalid_d = 1'b1;
            mdata_d  = DW'({half[1], half[0]});
        end else if (M_AXIS_tready) begin
            mvalid_d = 1'b0;
        end
    end

    // A clip landing in the same cycle as a clear wins.
    always_comb begin
`ifdef SIGNAL_MERGE_SAT_EN
        sat_d = sat_clr ? 2'b00 : sat_q;
        if (load) sat_d = sat_d | clip;
`else
        sat_d = 2'b00;
`endif
    end

`ifndef SIGNAL_MERGE_SAT_EN
    logic unused_bits;
    assign unused_bits = ^{sat_clr, clip, s[0][DW-1:AW], s[1][DW-1:AW]};
`endif

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int c = 0; c < 2; c++) cnt_q[c] <= 2'd0;
            wr_q     <= 2'b00;
            rd_q     <= 2'b00;
            rdy_q    <= 2'b00;
            mvalid_q <= 1'b0;
            mdata_q  <= '0;
            sat_q    <= 2'b00;
        end else begin
            for (int c = 0; c < 2; c++) cnt_q[c] <= cnt_d[c];
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            rdy_q    <= rdy_d;
            mvalid_q <= mvalid_d;
            mdata_q  <= mdata_d;
            sat_q    <= sat_d;
        end
    end

    always_ff @(posedge aclk) begin
        for (int c = 0; c < 2; c++) begin
            if (push[c]) mem_q[c][wr_q[c]] <= in_data[c];
        end
    end

    assign S_AXIS_tready_PORT1 = rdy_q[0];
    assign S_AXIS_tready_PORT2 = rdy_q[1];
    assign M_AXIS_tvalid       = mvalid_q;
    assign M_AXIS_tdata        = mdata_q;
    assign sat_flag            = sat_q;
endmodule

// File: tb/tb_signal_merge.sv
// Directed bench for signal_merge: packing, saturation/wrap, shift, skew, backpressure, streaming, reset.
`timescale 1ns/1ps
module tb_signal_merge;
    logic        clk = 1'b0;
    logic        areset;
    logic [31:0] d1, d2, m_data;
    logic        v1, v2, r1, r2, m_valid, m_ready, sat_clr;
    logic [1:0]  sat_flag;
    logic [31:0] sd1, sd2, sm_data;
    logic        sv1, sv2, sr1, sr2, sm_valid, sm_ready, s_sat_clr;
    logic [1:0]  s_sat_flag;
    int          errors = 0;
    int          checks = 0;

`ifdef SIGNAL_MERGE_SAT_EN
    localparam logic [31:0] SAT_WORD  = 32'h8000_7FFF;
    localparam logic [1:0]  SAT_BOTH  = 2'b11;
    localparam logic [31:0] SAT_WORD2 = 32'h8000_7FFF;
    localparam logic [1:0]  SAT_ONE   = 2'b01;
`else
    localparam logic [31:0] SAT_WORD  = 32'h0000_0000;
    localparam logic [1:0]  SAT_BOTH  = 2'b00;
    localparam logic [31:0] SAT_WORD2 = 32'h8000_8000;
    localparam logic [1:0]  SAT_ONE   = 2'b00;
`endif

    logic [31:0] bb1 [4] = '{32'h0000_0001, 32'h0000_7FFF, 32'hFFFF_8000, 32'h0000_0ABC};
    logic [31:0] bb2 [4] = '{32'hFFFF_FFFF, 32'h0000_0005, 32'h0000_1111, 32'hFFFF_F000};
    logic [31:0] bbx [4] = '{32'hFFFF_0001, 32'h0005_7FFF, 32'h1111_8000, 32'hF000_0ABC};

    always #5 clk = ~clk;

    signal_merge dut (
        .aclk(clk), .areset(areset),
        .S_AXIS_tdata_PORT1(d1), .S_AXIS_tvalid_PORT1(v1), .S_AXIS_tready_PORT1(r1),
        .S_AXIS_tdata_PORT2(d2), .S_AXIS_tvalid_PORT2(v2), .S_AXIS_tready_PORT2(r2),
        .M_AXIS_tdata(m_data), .M_AXIS_tvalid(m_valid), .M_AXIS_tready(m_ready),
        .sat_clr(sat_clr), .sat_flag(sat_flag)
    );

    signal_merge #(.SHIFT(4)) u_shift (
        .aclk(clk), .areset(areset),
        .S_AXIS_tdata_PORT1(sd1), .S_AXIS_tvalid_PORT1(sv1), .S_AXIS_tready_PORT1(sr1),
        .S_AXIS_tdata_PORT2(sd2), .S_AXIS_tvalid_PORT2(sv2), .S_AXIS_tready_PORT2(sr2),
        .M_AXIS_tdata(sm_data), .M_AXIS_tvalid(sm_valid), .M_AXIS_tready(sm_ready),
        .sat_clr(s_sat_clr), .sat_flag(s_sat_flag)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        areset = 1'b1; v1 = 1'b0; v2 = 1'b0; d1 = '0; d2 = '0; m_ready = 1'b0; sat_clr = 1'b0;
        sv1 = 1'b0; sv2 = 1'b0; sd1 = '0; sd2 = '0; sm_ready = 1'b1; s_sat_clr = 1'b0;
        repeat (3) step();
        checks++; if (r1 !== 1'b0) begin errors++; $display("FAIL rst_rdy1: got %b want 0", r1); end
        checks++; if (r2 !== 1'b0) begin errors++; $display("FAIL rst_rdy2: got %b want 0", r2); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", m_valid); end
        checks++; if (m_data !== 32'h0) begin errors++; $display("FAIL rst_data: got %h want 0", m_data); end
        checks++; if (sat_flag !== 2'b00) begin errors++; $display("FAIL rst_sat: got %b want 00", sat_flag); end
        areset = 1'b0;
        #1;
        checks++; if (r1 !== 1'b0) begin errors++; $display("FAIL rel_rdy_early: got %b want 0", r1); end
        step();
        checks++; if (r1 !== 1'b1) begin errors++; $display("FAIL rel_rdy1: got %b want 1", r1); end
        checks++; if (r2 !== 1'b1) begin errors++; $display("FAIL rel_rdy2: got %b want 1", r2); end
    endtask

    task automatic test_pack();
        d1 = 32'h0000_1234; d2 = 32'hFFFF_FFFE; v1 = 1'b1; v2 = 1'b1; m_ready = 1'b1;
        step();
        v1 = 1'b0; v2 = 1'b0;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL pack_early: valid %b want 0", m_valid); end
        step();
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL pack_valid: got %b want 1", m_valid); end
        checks++; if (m_data !== 32'hFFFE_1234) begin errors++; $display("FAIL pack_data: got %h want fffe1234", m_data); end
        checks++; if (sat_flag !== 2'b00) begin errors++; $display("FAIL pack_sat: got %b want 00", sat_flag); end
        step();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL pack_drain: valid %b want 0", m_valid); end
    endtask

    task automatic test_saturation();
        d1 = 32'h0001_0000; d2 = 32'hFFFE_0000; v1 = 1'b1; v2 = 1'b1; m_ready = 1'b1;
        step();
        v1 = 1'b0; v2 = 1'b0;
        step();
        checks++; if (m_data !== SAT_WORD) begin errors++; $display("FAIL sat_data: got %h want %h", m_data, SAT_WORD); end
        checks++; if (sat_flag !== SAT_BOTH) begin errors++; $display("FAIL sat_flag: got %b want %b", sat_flag, SAT_BOTH); end
        step();
        checks++; if (sat_flag !== SAT_BOTH) begin errors++; $display("FAIL sat_sticky: got %b want %b", sat_flag, SAT_BOTH); end
        d1 = 32'h0000_8000; d2 = 32'hFFFF_8000; v1 = 1'b1; v2 = 1'b1;
        step();
        v1 = 1'b0; v2 = 1'b0; sat_clr = 1'b1;
        step();
        checks++; if (m_data !== SAT_WORD2) begin errors++; $display("FAIL sat_data2: got %h want %h", m_data, SAT_WORD2); end
        checks++; if (sat_flag !== SAT_ONE) begin errors++; $display("FAIL sat_clr_clip: got %b want %b", sat_flag, SAT_ONE); end
        step();
        sat_clr = 1'b0;
        checks++; if (sat_flag !== 2'b00) begin errors++; $display("FAIL sat_clear: got %b want 00", sat_flag); end
    endtask

    task automatic test_shift();
        sd1 = 32'h0000_1230; sd2 = 32'hFFFF_FF00; sv1 = 1'b1; sv2 = 1'b1; sm_ready = 1'b1;
        step();
        sv1 = 1'b0; sv2 = 1'b0;
        step();
        checks++; if (sm_valid !== 1'b1) begin errors++; $display("FAIL shift_valid: got %b want 1", sm_valid); end
        checks++; if (sm_data !== 32'hFFF0_0123) begin errors++; $display("FAIL shift_data: got %h want fff00123", sm_data); end
    endtask

    task automatic test_skew_backpressure();
        m_ready = 1'b1; v1 = 1'b1; d1 = 32'h0000_0101;
        checks++; if (r1 !== 1'b1) begin errors++; $display("FAIL skew_rdy0: got %b want 1", r1); end
        step(); d1 = 32'h0000_0102;
        step(); d1 = 32'h0000_0103;
        checks++; if (r1 !== 1'b0) begin errors++; $display("FAIL skew_full: got %b want 0", r1); end
        step();
        checks++; if (r1 !== 1'b0) begin errors++; $display("FAIL skew_hold: got %b want 0", r1); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL skew_noout: valid %b want 0", m_valid); end
        v2 = 1'b1; d2 = 32'h0000_0201;
        step();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL skew_wait: valid %b want 0", m_valid); end
        d2 = 32'h0000_0202;
        step();
        checks++; if (m_valid !== 1'b1 || m_data !== 32'h0201_0101) begin errors++; $display("FAIL skew_w0: got %b/%h want 1/02010101", m_valid, m_data); end
        m_ready = 1'b0; d2 = 32'h0000_0203;
        step();
        checks++; if (m_valid !== 1'b1 || m_data !== 32'h0201_0101) begin errors++; $display("FAIL skew_stall0: got %b/%h want 1/02010101", m_valid, m_data); end
        checks++; if (r1 !== 1'b0 || r2 !== 1'b0) begin errors++; $display("FAIL skew_bothfull: got %b%b want 00", r2, r1); end
        v1 = 1'b0; v2 = 1'b0; m_ready = 1'b1;
        step();
        checks++; if (m_valid !== 1'b1 || m_data !== 32'h0202_0102) begin errors++; $display("FAIL skew_w1: got %b/%h want 1/02020102", m_valid, m_data); end
        m_ready = 1'b0;
        step();
        checks++; if (m_valid !== 1'b1 || m_data !== 32'h0202_0102) begin errors++; $display("FAIL skew_stall1: got %b/%h want 1/02020102", m_valid, m_data); end
        m_ready = 1'b1;
        step();
        checks++; if (m_valid !== 1'b1 || m_data !== 32'h0203_0103) begin errors++; $display("FAIL skew_w2: got %b/%h want 1/02030103", m_valid, m_data); end
        step();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL skew_end: valid %b want 0", m_valid); end
    endtask

    task automatic test_back_to_back();
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                v1 = 1'b1; v2 = 1'b1; d1 = bb1[i]; d2 = bb2[i];
            end else begin
                v1 = 1'b0; v2 = 1'b0;
            end
            step();
            if (i >= 1) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== bbx[i-1]) begin
                    errors++; $display("FAIL b2b_%0d: got %b/%h want 1/%h", i - 1, m_valid, m_data, bbx[i-1]);
                end
            end
        end
        step();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL b2b_end: valid %b want 0", m_valid); end
    endtask

    task automatic test_reset_midstream();
        m_ready = 1'b0; v1 = 1'b1; v2 = 1'b1;
        d1 = 32'h0000_0011; d2 = 32'h0000_0021;
        step(); d1 = 32'h0000_0012; d2 = 32'h0000_0022;
        step(); d1 = 32'h0000_0013; d2 = 32'h0000_0023;
        step(); v1 = 1'b0; v2 = 1'b0;
        checks++; if (r1 !== 1'b0 || r2 !== 1'b0 || m_valid !== 1'b1) begin errors++; $display("FAIL mid_pre: rdy %b%b valid %b want 00/1", r2, r1, m_valid); end
        areset = 1'b1;
        #1;
        checks++; if (r1 !== 1'b0 || r2 !== 1'b0) begin errors++; $display("FAIL mid_rdy: got %b%b want 00", r2, r1); end
        checks++; if (m_valid !== 1'b0 || m_data !== 32'h0) begin errors++; $display("FAIL mid_out: got %b/%h want 0/0", m_valid, m_data); end
        step();
        areset = 1'b0;
        step();
        checks++; if (r1 !== 1'b1 || r2 !== 1'b1) begin errors++; $display("FAIL mid_rel: got %b%b want 11", r2, r1); end
        d1 = 32'h0000_0AAA; d2 = 32'h0000_0555; v1 = 1'b1; v2 = 1'b1; m_ready = 1'b1;
        step();
        v1 = 1'b0; v2 = 1'b0;
        step();
        checks++; if (m_valid !== 1'b1 || m_data !== 32'h0555_0AAA) begin errors++; $display("FAIL mid_first: got %b/%h want 1/05550aaa", m_valid, m_data); end
        step();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL mid_nostale: valid %b want 0", m_valid); end
    endtask

    initial begin
        test_reset();
        test_pack();
        test_saturation();
        test_shift();
        test_skew_backpressure();
        test_back_to_back();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end
endmodule
